pc_redirect_unit: RTL

//  Program-counter stage for the LEGv8 fetch path. Holds the current fetch PC
//    and hands it to instruction fetch through a valid/ready handshake.

---
 rtl/pc_redirect_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pc_redirect_unit.sv
// LEGv8 fetch-path PC stage: valid/ready fetch handshake, branch-target redirect with a
// one-deep pending buffer for stalled fetches, and IDLE/RUN/HALTED sequencing.
// Optional accepted-redirect counter enabled by defining BRANCH_CNT_EN.
module pc_redirect_unit #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt_req,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_base,
  input  logic [ADDR_W-1:0] shifted_offset,
  input  logic              fetch_ready,
  output logic              fetch_valid,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic              redirect_pend,
  output logic              misalign_err,
  output logic [31:0]       branch_count
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              redirect_pend_q, redirect_pend_d;
  logic              misalign_q, misalign_d;
  logic              halt_pend_q, halt_pend_d;
  logic              load_redirect;

  logic [ADDR_W-1:0] target_raw;
  logic [ADDR_W-1:0] target;
  logic              accept;

  assign target_raw  = branch_base + shifted_offset;
  assign target      = {target_raw[ADDR_W-1:2], 2'b00};
  assign fetch_valid = (state_q == ST_RUN);
  assign accept      = fetch_valid & fetch_ready;

  // NOTE: every signal gets a default at the top of the block so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d         = state_q;
    fetch_pc_d      = fetch_pc_q;
    pend_pc_d       = pend_pc_q;
    redirect_pend_d = redirect_pend_q;
    halt_pend_d     = halt_pend_q;
    misalign_d      = misalign_q;
    load_redirect   = 1'b0;

    if (branch_taken && (target_raw[1:0] != 2'b00)) misalign_d = 1'b1;

    case (state_q)
      ST_RUN: begin
        if (accept) begin
          // A same-cycle branch is newer than anything buffered, so it also retires the pending one.
          if (branch_taken) begin
            fetch_pc_d      = target;
            redirect_pend_d = 1'b0;
            load_redirect   = 1'b1;
          end else if (redirect_pend_q) begin
            fetch_pc_d      = pend_pc_q;
            redirect_pend_d = 1'b0;
            load_redirect   = 1'b1;
          end else begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
          end
          if (halt_req || halt_pend_q) begin
            state_d     = ST_HALTED;
            halt_pend_d = 1'b0;
          end
        end else begin
          if (branch_taken) begin
            pend_pc_d       = target;
            redirect_pend_d = 1'b1;
          end
          if (halt_req) halt_pend_d = 1'b1;
        end
      end
      ST_IDLE, ST_HALTED: begin
        halt_pend_d = 1'b0;
        if (branch_taken) begin
          fetch_pc_d      = target;
          redirect_pend_d = 1'b0;
          load_redirect   = 1'b1;
        end
        if (start) state_d = ST_RUN;
      end
      default: begin
        state_d         = ST_IDLE;
        redirect_pend_d = 1'b0;
        halt_pend_d     = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      fetch_pc_q      <= RESET_PC;
      // NOTE: the pending target is a plain register, not a memory, so it is reset
      // along with the rest; a reset mid-stall must leave nothing behind.
      pend_pc_q       <= '0;
      redirect_pend_q <= 1'b0;
      misalign_q      <= 1'b0;
      halt_pend_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      fetch_pc_q      <= fetch_pc_d;
      pend_pc_q       <= pend_pc_d;
      redirect_pend_q <= redirect_pend_d;
      misalign_q      <= misalign_d;
      halt_pend_q     <= halt_pend_d;
    end
  end

  assign fetch_pc      = fetch_pc_q;
  assign redirect_pend = redirect_pend_q;
  assign misalign_err  = misalign_q;

`ifdef BRANCH_CNT_EN
  logic [31:0] branch_count_q, branch_count_d;

  always_comb begin
    branch_count_d = branch_count_q;
    if (load_redirect && (branch_count_q != 32'hFFFF_FFFF)) branch_count_d = branch_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) branch_count_q <= '0;
    else        branch_count_q <= branch_count_d;
  end

  assign branch_count = branch_count_q;
`else
  logic unused_load_redirect;
  assign unused_load_redirect = load_redirect;
  assign branch_count         = 32'd0;
`endif

endmodule
